pipeline_stall_ctrl: RTL and testbench

Consumer end of the hazard-detection interface. Takes hazard_detected from the ID-stage hazard unit, the taken-branch indication from EXE, and the data-memory wait signal, and drives the pipeline-register write enables and flushes. It is a small FSM with a stall watchdog and saturating performance counters. It sits beside the top-level datapath between the hazard unit and the IF/ID, ID/EX and EX/MEM registers.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 16 +
 rtl/pipeline_stall_ctrl_if.sv | 24 ++
 rtl/pipeline_stall_ctrl_sat_counter.sv | 12 +
 rtl/pipeline_stall_ctrl.sv | 52 +++++
 tb/tb_pipeline_stall_ctrl.sv | 120 ++++++++++++
 5 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// pipeline_stall_ctrl_pkg: shared stall-controller states, control bundle and NOP constants.
package pipeline_stall_ctrl_pkg;
    typedef enum logic [1:0] {RUN, HZ_STALL, BR_FLUSH, MEM_FREEZE} state_t;
    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_we;
    } ctrl_t;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam ctrl_t       CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam ctrl_t       CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t       CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam ctrl_t       CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if: hazard inputs and pipeline-register controls between hazard unit and datapath.
interface pipeline_stall_ctrl_if #(parameter int CNT_W = 16);
    logic             hazard_detected;
    logic             branch_taken_exe;
    logic             mem_busy;
    logic             pc_write_en;
    logic             if_id_write_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_write_en;
    logic             hazard_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    modport master (
        output hazard_detected, branch_taken_exe, mem_busy,
        input  pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, ex_mem_write_en,
        input  hazard_timeout, stall_cycles, flush_events
    );
    modport slave (
        input  hazard_detected, branch_taken_exe, mem_busy,
        output pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, ex_mem_write_en,
        output hazard_timeout, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// sat_counter: counter that sticks at all-ones instead of wrapping.
module sat_counter #(parameter int W = 16) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else count <= clr ? '0 : (inc && !(&count)) ? count + W'(1) : count;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: drives pipeline write enables/flushes from hazard, branch and memory-wait inputs,
// with a sticky stall watchdog and saturating stall/flush counters.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    pipeline_stall_ctrl_if.slave bus
);
    localparam int SW = $clog2(MAX_STALL + 1);
    state_t        state, ret_state, eff_state, next_state;
    logic [SW-1:0] stall_run, stall_run_inc;
    logic          qual_hz, flush_inc, timeout;
    ctrl_t         ctrl;
    always_comb begin
        // a freeze is transparent: on release we decide as if still in the pre-freeze state
        eff_state     = (state == MEM_FREEZE) ? ret_state : state;
        qual_hz       = bus.hazard_detected && !bus.mem_busy && !bus.branch_taken_exe && eff_state != BR_FLUSH;
        flush_inc     = bus.branch_taken_exe && !bus.mem_busy;
        next_state    = bus.mem_busy ? MEM_FREEZE : flush_inc ? BR_FLUSH : qual_hz ? HZ_STALL : RUN;
        ctrl          = !rst_n ? CTRL_RUN : bus.mem_busy ? CTRL_FREEZE : flush_inc ? CTRL_FLUSH :
                        qual_hz ? CTRL_STALL : CTRL_RUN;
        stall_run_inc = (stall_run == SW'(MAX_STALL)) ? stall_run : stall_run + SW'(1);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= RUN;
            ret_state <= RUN;
            stall_run <= '0;
            timeout   <= 1'b0;
        end else begin
            state <= next_state;
            if (bus.mem_busy && state != MEM_FREEZE) ret_state <= state;
            if (!bus.mem_busy) stall_run <= qual_hz ? stall_run_inc : '0;
            if (qual_hz && stall_run_inc == SW'(MAX_STALL)) timeout <= 1'b1;
        end
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst_n(rst_n), .inc(qual_hz), .clr(1'b0), .count(bus.stall_cycles)
    );
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(clk), .rst_n(rst_n), .inc(flush_inc), .clr(1'b0), .count(bus.flush_events)
    );
    assign bus.pc_write_en     = ctrl.pc_we;
    assign bus.if_id_write_en  = ctrl.ifid_we;
    assign bus.if_id_flush     = ctrl.ifid_flush;
    assign bus.id_ex_flush     = ctrl.idex_flush;
    assign bus.ex_mem_write_en = ctrl.exmem_we;
    assign bus.hazard_timeout  = timeout;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: table-driven directed check of stall/flush/freeze control, watchdog and counters.
module tb_pipeline_stall_ctrl;
    localparam int CW = 3;
    localparam logic [4:0] R = 5'b11001;
    localparam logic [4:0] S = 5'b00011;
    localparam logic [4:0] F = 5'b11111;
    localparam logic [4:0] Z = 5'b00000;
    typedef struct {
        logic          hz, br, mb;
        logic [4:0]    ctl;
        logic          to;
        logic [CW-1:0] sc, fe;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[31];
    always #5 clk = ~clk;
    pipeline_stall_ctrl_if #(.CNT_W(CW)) bus ();
    pipeline_stall_ctrl #(.CNT_W(CW), .MAX_STALL(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    function automatic vec_t v(input logic hz, br, mb, input logic [4:0] ctl, input logic to, input int sc, fe);
        vec_t r;
        r.hz = hz; r.br = br; r.mb = mb; r.ctl = ctl; r.to = to;
        r.sc = CW'(sc); r.fe = CW'(fe);
        return r;
    endfunction
    task automatic cmp(input string nm, input int idx, input logic [4:0] got, exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %b expected %b", nm, idx, got, exp);
        end
    endtask
    task automatic check_all(input string nm, input int idx, input logic [4:0] ctl, input logic to, input int sc, fe);
        cmp({nm, "_ctl"}, idx, {bus.pc_write_en, bus.if_id_write_en, bus.if_id_flush,
                               bus.id_ex_flush, bus.ex_mem_write_en}, ctl);
        cmp({nm, "_timeout"}, idx, {4'b0, bus.hazard_timeout}, {4'b0, to});
        cmp({nm, "_stall_cycles"}, idx, 5'(bus.stall_cycles), 5'(sc));
        cmp({nm, "_flush_events"}, idx, 5'(bus.flush_events), 5'(fe));
    endtask
    task automatic drive(input logic hz, br, mb);
        @(negedge clk);
        bus.hazard_detected = hz; bus.branch_taken_exe = br; bus.mem_busy = mb;
        #1;
    endtask
    initial begin
        bus.hazard_detected = 1'b0; bus.branch_taken_exe = 1'b0; bus.mem_busy = 1'b0;
        // load-use, then branch with simultaneous hazard and a suppressed follow-up hazard
        vecs[0]  = v(0,0,0, R,0,0,0);
        vecs[1]  = v(1,0,0, S,0,0,0);
        vecs[2]  = v(0,0,0, R,0,1,0);
        vecs[3]  = v(1,1,0, F,0,1,0);
        vecs[4]  = v(1,0,0, R,0,1,1);
        vecs[5]  = v(0,0,0, R,0,1,1);
        // freeze in the middle of a stall, stall resumes on release
        vecs[6]  = v(1,0,0, S,0,1,1);
        vecs[7]  = v(1,0,1, Z,0,2,1);
        vecs[8]  = v(1,0,1, Z,0,2,1);
        vecs[9]  = v(1,0,1, Z,0,2,1);
        vecs[10] = v(1,0,0, S,0,2,1);
        vecs[11] = v(0,0,0, R,0,3,1);
        // watchdog: five held hazard cycles, stall counter saturates at 7
        vecs[12] = v(1,0,0, S,0,3,1);
        vecs[13] = v(1,0,0, S,0,4,1);
        vecs[14] = v(1,0,0, S,0,5,1);
        vecs[15] = v(1,0,0, S,0,6,1);
        vecs[16] = v(1,0,0, S,1,7,1);
        vecs[17] = v(0,0,0, R,1,7,1);
        vecs[18] = v(0,0,0, R,1,7,1);
        // flush suppression survives a freeze; branch held across freeze counts once
        vecs[19] = v(0,1,0, F,1,7,1);
        vecs[20] = v(1,0,1, Z,1,7,2);
        vecs[21] = v(1,0,0, R,1,7,2);
        vecs[22] = v(0,1,1, Z,1,7,2);
        vecs[23] = v(0,1,0, F,1,7,2);
        // flush counter saturation after nine flushes in total
        vecs[24] = v(0,1,0, F,1,7,3);
        vecs[25] = v(0,1,0, F,1,7,4);
        vecs[26] = v(0,1,0, F,1,7,5);
        vecs[27] = v(0,1,0, F,1,7,6);
        vecs[28] = v(0,1,0, F,1,7,7);
        vecs[29] = v(0,1,0, F,1,7,7);
        vecs[30] = v(0,0,0, R,1,7,7);
        bus.hazard_detected = 1'b1; bus.branch_taken_exe = 1'b1; bus.mem_busy = 1'b1;
        #1;
        check_all("in_reset", 0, R, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 31; i++) begin
            drive(vecs[i].hz, vecs[i].br, vecs[i].mb);
            check_all("vec", i, vecs[i].ctl, vecs[i].to, vecs[i].sc, vecs[i].fe);
        end
        // reset pulse clears sticky timeout and counters
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all("rst_clr", 0, R, 0, 0, 0);
        rst_n = 1'b1;
        // async reset between edges while frozen out of BR_FLUSH
        drive(0, 1, 0);
        check_all("seq_br", 0, F, 0, 0, 0);
        drive(1, 0, 1);
        check_all("seq_frz", 0, Z, 0, 0, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 0, R, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.hazard_detected = 1'b1; bus.mem_busy = 1'b0;
        #1;
        check_all("post_rst_hz", 0, S, 0, 0, 0);
        drive(0, 0, 0);
        check_all("post_rst_idle", 0, R, 0, 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
